// File: rtl/spike_pattern_readout.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : spike_pattern_readout
//  Description : Readout stage for the Hopfield network's spike bus.
//                Integrates per-neuron spike onsets over a fixed window after
//                a start request. It thresholds the counts into a binary
//                pattern and offers the pattern on a valid/ready handshake.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i            : system clock, rising-edge logic
//    reset_i          : synchronous active-high reset
//    start_i          : request a readout window (pulse or level)
//    spikes_i[N]      : spike outputs of the Hopfield network
//    busy_o           : high while integrating
//    pattern_valid_o  : recalled pattern available
//    pattern_ready_i  : consumer accepts the pattern
//    pattern_out_o[N] : recalled pattern, bit i = neuron i active
//    winner_idx_o     : index of the largest count (READOUT_WINNER_EN only)
//  Build option
//    READOUT_WINNER_EN : when defined, adds winner_idx_o and its comparator
//                        chain. Ties go to the lowest index.
// ============================================================================
module spike_pattern_readout #(
  parameter int N      = 7,
  parameter int WINDOW = 256,
  parameter int CNT_W  = 8,
  parameter int THRESH = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [N-1:0]         spikes_i,
  output logic                 busy_o,
  output logic                 pattern_valid_o,
  input  logic                 pattern_ready_i,
  output logic [N-1:0]         pattern_out_o
`ifdef READOUT_WINNER_EN
  ,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] winner_idx_o
`endif
);

  localparam int              WC_W     = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_INTEGRATE = 2'd1,
    ST_DONE      = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [N-1:0]              spike_prev_q;
  logic [N-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [WC_W-1:0]           win_q, win_d;
  logic [N-1:0]              pattern_q, pattern_d;

  // Count of each neuron including the onset seen this cycle. The last
  // integrate cycle uses this value, so its onsets reach the threshold.
  logic [N-1:0][CNT_W-1:0]   cnt_inc;
  logic [N-1:0]              above_thresh;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_neuron
      logic onset;
      // Only a rising edge counts. A spike held high counts once.
      assign onset           = spikes_i[gi] & ~spike_prev_q[gi];
      assign cnt_inc[gi]     = (onset && (cnt_q[gi] != CNT_MAX))
                               ? cnt_q[gi] + CNT_W'(1) : cnt_q[gi];
      assign above_thresh[gi] = (cnt_inc[gi] >= THRESH_C);
    end
  endgenerate

`ifdef READOUT_WINNER_EN
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] winner_q, winner_d;
  logic [IDX_W-1:0] winner_w;
  logic [CNT_W-1:0] best_w;

  // Linear arg-max. A strict '>' keeps the lowest index on ties.
  // All-zero counts leave the index at 0.
  always_comb begin
    best_w   = cnt_inc[0];
    winner_w = '0;
    for (int i = 1; i < N; i++) begin
      if (cnt_inc[i] > best_w) begin
        best_w   = cnt_inc[i];
        winner_w = IDX_W'(i);
      end
    end
  end

  assign winner_idx_o = winner_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    pattern_d = pattern_q;
`ifdef READOUT_WINNER_EN
    winner_d  = winner_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_INTEGRATE;
          cnt_d   = '0;
          win_d   = '0;
        end
      end
      ST_INTEGRATE: begin
        cnt_d = cnt_inc;
        win_d = win_q + WC_W'(1);
        if (win_q == WIN_LAST) begin
          pattern_d = above_thresh;
`ifdef READOUT_WINNER_EN
          winner_d  = winner_w;
`endif
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        // Outputs hold until accepted. Accept together with start begins
        // the next window at once.
        if (pattern_ready_i) begin
          if (start_i) begin
            state_d = ST_INTEGRATE;
            cnt_d   = '0;
            win_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      spike_prev_q <= '0;
      cnt_q        <= '0;
      win_q        <= '0;
      pattern_q    <= '0;
`ifdef READOUT_WINNER_EN
      winner_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      // The previous sample is tracked in every state. The first integrate
      // cycle therefore sees a correct edge.
      spike_prev_q <= spikes_i;
      cnt_q        <= cnt_d;
      win_q        <= win_d;
      pattern_q    <= pattern_d;
`ifdef READOUT_WINNER_EN
      winner_q     <= winner_d;
`endif
    end
  end

  assign busy_o          = (state_q == ST_INTEGRATE);
  assign pattern_valid_o = (state_q == ST_DONE);
  assign pattern_out_o   = pattern_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_pattern_readout.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spike_pattern_readout
//  Description : Self-checking bench for spike_pattern_readout.
//                Uses WINDOW=16, THRESH=2, N=7. A second instance with
//                CNT_W=2 exercises counter saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spike_pattern_readout;

  localparam int N   = 7;
  localparam int WIN = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, ready;
  logic [N-1:0] spikes;
  logic         busy, valid;
  logic [N-1:0] pat;

  logic         s_start, s_ready;
  logic [N-1:0] s_spikes;
  logic         s_busy, s_valid;
  logic [N-1:0] s_pat;

`ifdef READOUT_WINNER_EN
  logic [2:0] widx, s_widx;
`endif

  spike_pattern_readout #(.N(N), .WINDOW(WIN), .CNT_W(8), .THRESH(2)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .start_i         (start),
    .spikes_i        (spikes),
    .busy_o          (busy),
    .pattern_valid_o (valid),
    .pattern_ready_i (ready),
    .pattern_out_o   (pat)
`ifdef READOUT_WINNER_EN
    ,
    .winner_idx_o    (widx)
`endif
  );

  spike_pattern_readout #(.N(N), .WINDOW(24), .CNT_W(2), .THRESH(3)) dut_sat (
    .clk_i           (clk),
    .reset_i         (reset),
    .start_i         (s_start),
    .spikes_i        (s_spikes),
    .busy_o          (s_busy),
    .pattern_valid_o (s_valid),
    .pattern_ready_i (s_ready),
    .pattern_out_o   (s_pat)
`ifdef READOUT_WINNER_EN
    ,
    .winner_idx_o    (s_widx)
`endif
  );

  typedef struct {
    int           pulses[N];
    logic [N-1:0] held;
    logic [N-1:0] exp_pat;
    int           exp_win;
  } vec_t;

  typedef struct {
    logic [N-1:0] pat;
    int           win;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  vec_t zero_v;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] spike_at(input vec_t v, input int j);
    logic [N-1:0] s;
    for (int i = 0; i < N; i++)
      s[i] = v.held[i] | ((j < 2 * v.pulses[i]) && (j % 2 == 0));
    return s;
  endfunction

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.pat = v.exp_pat;
    e.win = v.exp_win;
    sb.push_back(e);
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty actual=%0h", tag, pat);
    end else begin
      e = sb.pop_front();
      chk({tag, " pattern"}, 32'(pat), 32'(e.pat));
`ifdef READOUT_WINNER_EN
      chk({tag, " winner"}, 32'(widx), 32'(e.win));
`endif
    end
  endtask

  // Entered at a negedge in IDLE. Returns at the negedge where valid is expected.
  task automatic integrate(input vec_t v, input string tag);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    start = 1'b1;
    push_exp(v);
    for (int j = 0; j < WIN; j++) begin
      @(negedge clk);
      start  = 1'b0;
      spikes = spike_at(v, j);
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " early valid"}, 32'(valid), 32'd0);
    end
    @(negedge clk);
    spikes = '0;
    chk({tag, " latency valid"}, 32'(valid), 32'd1);
    chk({tag, " done busy"}, 32'(busy), 32'd0);
  endtask

  task automatic accept(input string tag);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk({tag, " valid drop"}, 32'(valid), 32'd0);
  endtask

  task automatic run_window(input vec_t v, input string tag);
    integrate(v, tag);
    check_pop(tag);
    accept(tag);
  endtask

  initial begin
    vecs[0] = '{pulses: '{3,0,1,0,0,2,0}, held: 7'h00,       exp_pat: 7'b0100001, exp_win: 0};
    vecs[1] = '{pulses: '{0,0,0,0,0,0,2}, held: 7'b0001000,  exp_pat: 7'b1000000, exp_win: 6};
    vecs[2] = '{pulses: '{2,2,2,2,2,2,2}, held: 7'h00,       exp_pat: 7'b1111111, exp_win: 0};
    vecs[3] = '{pulses: '{1,1,1,1,1,1,1}, held: 7'h00,       exp_pat: 7'b0000000, exp_win: 0};
    vecs[4] = '{pulses: '{0,8,0,1,2,0,0}, held: 7'h00,       exp_pat: 7'b0010010, exp_win: 1};
    vecs[5] = '{pulses: '{0,0,0,0,0,0,0}, held: 7'h00,       exp_pat: 7'b0000000, exp_win: 0};
    vecs[6] = '{pulses: '{3,0,5,0,5,0,1}, held: 7'h00,       exp_pat: 7'b0010101, exp_win: 2};
    vecs[7] = '{pulses: '{0,0,1,0,0,0,4}, held: 7'b0100000,  exp_pat: 7'b1000000, exp_win: 6};
    zero_v  = vecs[5];

    reset = 1'b1; start = 1'b0; ready = 1'b0; spikes = '0;
    s_start = 1'b0; s_ready = 1'b0; s_spikes = '0;

    // Reset asserted for three cycles while the spikes toggle.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      spikes = ~spikes;
    end
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset pattern", 32'(pat), 32'd0);
    reset  = 1'b0;
    spikes = '0;
    @(negedge clk);
    chk("post-reset busy", 32'(busy), 32'd0);
    chk("post-reset valid", 32'(valid), 32'd0);

    for (int k = 0; k < 8; k++)
      run_window(vecs[k], $sformatf("vec%0d", k));

    // Backpressure: valid held, pattern stable, start ignored.
    integrate(vecs[0], "bp");
    check_pop("bp");
    for (int k = 0; k < 20; k++) begin
      ready = 1'b0;
      start = (k % 3 == 0);
      @(negedge clk);
      chk("bp valid held", 32'(valid), 32'd1);
      chk("bp no window", 32'(busy), 32'd0);
      chk("bp pattern stable", 32'(pat), 32'(7'b0100001));
    end
    ready = 1'b1;
    start = 1'b1;
    push_exp(zero_v);
    @(negedge clk);
    ready = 1'b0;
    start = 1'b0;
    chk("b2b valid drop", 32'(valid), 32'd0);
    chk("b2b busy", 32'(busy), 32'd1);
    for (int j = 1; j < WIN; j++) begin
      @(negedge clk);
      chk("b2b busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("b2b valid", 32'(valid), 32'd1);
    check_pop("b2b");
    accept("b2b");

    // Reset mid-window: latch a nonzero pattern, then abort a window.
    run_window(vecs[0], "pre-abort");
    start = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      start     = 1'b0;
      spikes    = '0;
      spikes[0] = (j % 2 == 0);
    end
    @(negedge clk);
    reset  = 1'b1;
    spikes = '0;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort valid", 32'(valid), 32'd0);
    chk("abort pattern", 32'(pat), 32'd0);
    begin
      vec_t fresh;
      fresh = '{pulses: '{1,0,2,0,0,0,0}, held: 7'h00, exp_pat: 7'b0000100, exp_win: 2};
      run_window(fresh, "fresh");
    end

    // Saturation: 10 onsets on a 2-bit counter stop at 3, which meets THRESH=3.
    s_start = 1'b1;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      s_start     = 1'b0;
      s_spikes    = '0;
      s_spikes[1] = (j < 20) && (j % 2 == 0);
      s_spikes[2] = (j < 4) && (j % 2 == 0);
      chk("sat busy", 32'(s_busy), 32'd1);
    end
    @(negedge clk);
    s_spikes = '0;
    chk("sat valid", 32'(s_valid), 32'd1);
    chk("sat pattern", 32'(s_pat), 32'(7'b0000010));
`ifdef READOUT_WINNER_EN
    chk("sat winner", 32'(s_widx), 32'd1);
`endif
    s_ready = 1'b1;
    @(negedge clk);
    s_ready = 1'b0;
    chk("sat valid drop", 32'(s_valid), 32'd0);

    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
